// File: rtl/line_sram_bridge.sv
// line_sram_bridge: splits one 512-bit line read or write into sixteen 32-bit SRAM word beats.
// Latency: accept at edge T, beats in cycles T+1..T+16 when there are no stalls, ws_ack pulses in cycle T+17.
// Backpressure: sram_nak=1 holds the current beat and the counter; dropping ws_cyc during XFER aborts with no ack.
//
// Ports:
//   clk, rstn                       - single clock; asynchronous active-low reset
//   ws_addr/ws_din/ws_dm/ws_we      - line request; latched when ws_cyc & ws_stb are seen in IDLE
//   ws_cyc/ws_stb                   - request qualifiers; ws_cyc low during XFER aborts
//   ws_dout/ws_ack                  - read line (held until the next read completes) and done pulse
//   sram_stb/addr/we/wdata          - registered word beat request; sram_we = 0000 means a read
//   sram_rdata/sram_nak             - read word, and the stall indication for the current beat
//   dbg_state                       - FSM encoding: IDLE=00, XFER=01, ACK=10
// Optional build macro LSB_SKIP_MASKED_EN: write beats whose byte mask is 0000 are not issued.
// Such a beat spends one cycle with sram_stb=0, and the counter still advances.

module line_sram_bridge #(
    parameter int LINE_WORDS = 16,
    parameter int ADDR_W     = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [ADDR_W-1:0]       ws_addr,
    input  logic [32*LINE_WORDS-1:0] ws_din,
    input  logic [4*LINE_WORDS-1:0] ws_dm,
    input  logic                    ws_cyc,
    input  logic                    ws_stb,
    input  logic                    ws_we,
    output logic [32*LINE_WORDS-1:0] ws_dout,
    output logic                    ws_ack,
    output logic                    sram_stb,
    output logic [ADDR_W-1:0]       sram_addr,
    output logic [3:0]              sram_we,
    output logic [31:0]             sram_wdata,
    input  logic [31:0]             sram_rdata,
    input  logic                    sram_nak,
    output logic [1:0]              dbg_state
);

    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam int OFS_W = CNT_W + 2;      // byte offset bits inside one line

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        XFER = 2'b01,
        ACK  = 2'b10
    } state_e;

    state_e                    state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [ADDR_W-1:0]         base_q;
    // Holds the write line. On a read it gathers the returned words instead,
    // because the write data is not needed then.
    logic [32*LINE_WORDS-1:0]  din_q;
    logic [4*LINE_WORDS-1:0]   dm_q;
    logic                      we_q;
    logic                      ack_q;
    logic                      stb_q;
    logic [ADDR_W-1:0]         addr_q;
    logic [3:0]                bwe_q;
    logic [31:0]               wdata_q;
    logic [32*LINE_WORDS-1:0]  dout_q;

    // Values for the next beat. In IDLE they come straight from the request
    // so that beat 0 is already on the bus in the cycle after accept.
    logic [CNT_W-1:0]          idx_d;
    logic [ADDR_W-1:0]         base_d;
    logic [32*LINE_WORDS-1:0]  din_d;
    logic [4*LINE_WORDS-1:0]   dm_d;
    logic                      we_d;
    logic [ADDR_W-1:0]         addr_d;
    logic [31:0]               wdata_d;
    logic [3:0]                nib_d;
    logic [3:0]                bwe_d;
    logic                      stb_d;
    logic [32*LINE_WORDS-1:0]  gather_d;
    logic                      beat_done;
    logic                      last_beat;
    logic                      unused_addr_bits;

    assign unused_addr_bits = ^ws_addr[OFS_W-1:0];

    always_comb begin
        idx_d    = '0;
        base_d   = {ws_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
        din_d    = ws_din;
        dm_d     = ws_dm;
        we_d     = ws_we;
        if (state_q != IDLE) begin
            idx_d  = cnt_q + 1'b1;
            base_d = base_q;
            din_d  = din_q;
            dm_d   = dm_q;
            we_d   = we_q;
        end
        addr_d  = base_d | ADDR_W'({idx_d, 2'b00});
        wdata_d = din_d[32*idx_d +: 32];
        nib_d   = dm_d[4*idx_d +: 4];
        bwe_d   = we_d ? nib_d : 4'b0000;
`ifdef LSB_SKIP_MASKED_EN
        stb_d   = !(we_d && (nib_d == 4'b0000));
`else
        stb_d   = 1'b1;
`endif
        gather_d = din_q;
        gather_d[32*cnt_q +: 32] = sram_rdata;
    end

    // A skipped beat (stb low in XFER) always advances, whatever nak says.
    assign beat_done = !stb_q || !sram_nak;
    assign last_beat = (cnt_q == CNT_W'(LINE_WORDS - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            din_q   <= '0;
            dm_q    <= '0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            stb_q   <= 1'b0;
            addr_q  <= '0;
            bwe_q   <= '0;
            wdata_q <= '0;
            dout_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q <= 1'b0;
                    if (ws_cyc && ws_stb) begin
                        state_q <= XFER;
                        cnt_q   <= '0;
                        base_q  <= base_d;
                        din_q   <= ws_din;
                        dm_q    <= ws_dm;
                        we_q    <= ws_we;
                        stb_q   <= stb_d;
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                        bwe_q   <= bwe_d;
                    end
                end
                XFER: begin
                    if (!ws_cyc) begin
                        // Abort: a beat taken at this edge is simply dropped.
                        state_q <= IDLE;
                        stb_q   <= 1'b0;
                        bwe_q   <= 4'b0000;
                    end else if (beat_done) begin
                        if (!we_q) begin
                            din_q <= gather_d;
                        end
                        if (last_beat) begin
                            state_q <= ACK;
                            ack_q   <= 1'b1;
                            stb_q   <= 1'b0;
                            bwe_q   <= 4'b0000;
                            if (!we_q) begin
                                dout_q <= gather_d;
                            end
                        end else begin
                            cnt_q   <= cnt_q + 1'b1;
                            stb_q   <= stb_d;
                            addr_q  <= addr_d;
                            wdata_q <= wdata_d;
                            bwe_q   <= bwe_d;
                        end
                    end
                end
                ACK: begin
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                    stb_q   <= 1'b0;
                    bwe_q   <= 4'b0000;
                end
            endcase
        end
    end

    assign ws_ack     = ack_q;
    assign ws_dout    = dout_q;
    assign sram_stb   = stb_q;
    assign sram_addr  = addr_q;
    assign sram_we    = bwe_q;
    assign sram_wdata = wdata_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_line_sram_bridge.sv
// tb_line_sram_bridge: directed bench for line_sram_bridge with a 64-word SRAM model.
// Latency: checks ack at T+17 when there are no stalls, and at T+20 with three nak cycles.
// Backpressure: injects sram_nak on chosen addresses, covers abort and mid-transfer reset.

module tb_line_sram_bridge;

    logic          clk;
    logic          rstn;
    logic [31:0]   ws_addr;
    logic [511:0]  ws_din;
    logic [63:0]   ws_dm;
    logic          ws_cyc;
    logic          ws_stb;
    logic          ws_we;
    logic [511:0]  ws_dout;
    logic          ws_ack;
    logic          sram_stb;
    logic [31:0]   sram_addr;
    logic [3:0]    sram_we;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;
    logic          sram_nak;
    logic [1:0]    dbg_state;

    line_sram_bridge #(.LINE_WORDS(16), .ADDR_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .ws_addr(ws_addr), .ws_din(ws_din), .ws_dm(ws_dm),
        .ws_cyc(ws_cyc), .ws_stb(ws_stb), .ws_we(ws_we),
        .ws_dout(ws_dout), .ws_ack(ws_ack),
        .sram_stb(sram_stb), .sram_addr(sram_addr), .sram_we(sram_we),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_nak(sram_nak),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef LSB_SKIP_MASKED_EN
    localparam int EXP_MASKED_STB = 2;
`else
    localparam int EXP_MASKED_STB = 16;
`endif

    int           n_chk, n_err;
    int           cycle, t0, ack_cyc;
    int           n_stb, n_acc, n_ack, n_wfull, n_watch, nak_left;
    logic [31:0]  nak_addr, watch_addr;
    logic [31:0]  acc_addr [32];
    logic [3:0]   acc_we [32];
    logic [31:0]  mem [64];
    logic [511:0] dout_cap, prev_dout, line, exp_line;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: advance past the edge, then play the SRAM slave and the line master.
    task automatic tick();
        int idx;
        @(posedge clk);
        #1;
        cycle++;
        sram_nak = 1'b0;
        if (sram_stb) begin
            n_stb++;
            if (sram_addr == watch_addr) n_watch++;
            if (sram_addr == nak_addr && nak_left > 0) begin
                sram_nak = 1'b1;
                nak_left--;
            end
            idx = int'(sram_addr[7:2]);
            sram_rdata = mem[idx];
            if (!sram_nak) begin
                if (n_acc < 32) begin
                    acc_addr[n_acc] = sram_addr;
                    acc_we[n_acc]   = sram_we;
                end
                n_acc++;
                if (sram_we == 4'hF) n_wfull++;
                for (int b = 0; b < 4; b++)
                    if (sram_we[b]) mem[idx][8*b +: 8] = sram_wdata[8*b +: 8];
            end
        end
        if (ws_ack) begin
            n_ack++;
            ack_cyc  = cycle;
            dout_cap = ws_dout;
            ws_cyc   = 1'b0;
            ws_stb   = 1'b0;
        end
    endtask

    task automatic clear_stats();
        n_stb = 0; n_acc = 0; n_ack = 0; n_wfull = 0; n_watch = 0;
        nak_left = 0; nak_addr = 32'hFFFF_FFFF; watch_addr = 32'hFFFF_FFFF;
        ack_cyc = 0;
    endtask

    task automatic start_txn(input logic [31:0] a, input logic we, input logic [511:0] d,
                             input logic [63:0] m);
        clear_stats();
        ws_addr = a; ws_we = we; ws_din = d; ws_dm = m;
        ws_cyc = 1'b1; ws_stb = 1'b1;
        t0 = cycle;
    endtask

    task automatic wait_ack();
        for (int k = 0; k < 60 && n_ack == 0; k++) tick();
        tick();   // step past the ACK cycle so the next request lands in IDLE
    endtask

    initial begin
        n_chk = 0; n_err = 0; cycle = 0;
        rstn = 1'b0; ws_addr = '0; ws_din = '0; ws_dm = '0;
        ws_cyc = 1'b0; ws_stb = 1'b0; ws_we = 1'b0;
        sram_rdata = '0; sram_nak = 1'b0;
        dout_cap = '0;
        clear_stats();
        for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 + 32'(i);

        // Reset state
        #12;
        chk("rst_ack", ws_ack, 0);
        chk("rst_stb", sram_stb, 0);
        chk("rst_we", sram_we, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_wdata", sram_wdata, 0);
        chk("rst_dout", ws_dout, 0);
        chk("rst_dbg", dbg_state, 2'b00);
        rstn = 1'b1;
        tick();

        // Read line at 0x1234, no stalls
        start_txn(32'h0000_1234, 1'b0, '0, '0);
        tick();
        chk("rd1_dbg_xfer", dbg_state, 2'b01);
        chk("rd1_beat0_stb", sram_stb, 1);
        wait_ack();
        for (int i = 0; i < 16; i++)
            chk($sformatf("rd1_addr%0d", i), acc_addr[i], 32'h1200 + 32'(4*i));
        chk("rd1_beats", n_acc, 16);
        chk("rd1_latency", ack_cyc - t0, 17);
        chk("rd1_acks", n_ack, 1);
        chk("rd1_w15", dout_cap[511:480], 32'hA500_000F);
        chk("rd1_w0", dout_cap[31:0], 32'hA500_0000);
        repeat (3) tick();
        chk("rd1_dout_hold", ws_dout[511:480], 32'hA500_000F);
        chk("idle_dbg", dbg_state, 2'b00);

        // Write full line, all bytes enabled
        for (int i = 0; i < 16; i++) line[32*i +: 32] = 32'(i) * 32'h0101_0101;
        start_txn(32'h0000_2000, 1'b1, line, {64{1'b1}});
        wait_ack();
        chk("wr1_beats", n_acc, 16);
        chk("wr1_we_full", n_wfull, 16);
        chk("wr1_mem7", mem[7], 32'h0707_0707);
        chk("wr1_mem15", mem[15], 32'h0F0F_0F0F);
        chk("wr1_acks", n_ack, 1);
        chk("wr1_latency", ack_cyc - t0, 17);
        chk("wr1_dout_kept", ws_dout[511:480], 32'hA500_000F);

        // Read with three nak cycles on beat 5
        start_txn(32'h0000_3000, 1'b0, '0, '0);
        nak_addr = 32'h3014; nak_left = 3; watch_addr = 32'h3014;
        wait_ack();
        chk("rd2_hold_cycles", n_watch, 4);
        chk("rd2_latency", ack_cyc - t0, 20);
        chk("rd2_w5", dout_cap[191:160], 32'h0505_0505);
        chk("rd2_w15", dout_cap[511:480], 32'h0F0F_0F0F);
        chk("rd2_beats", n_acc, 16);
        prev_dout = dout_cap;

        // Write with only words 0 and 3 enabled
        for (int i = 0; i < 16; i++) line[32*i +: 32] = 32'hB000_0000 + 32'(i);
        start_txn(32'h0000_4000, 1'b1, line, 64'h0000_0000_0000_F00F);
        wait_ack();
        chk("wr2_strobes", n_stb, EXP_MASKED_STB);
        chk("wr2_we_full", n_wfull, 2);
        chk("wr2_mem0", mem[0], 32'hB000_0000);
        chk("wr2_mem3", mem[3], 32'hB000_0003);
        chk("wr2_mem1_kept", mem[1], 32'h0101_0101);
        chk("wr2_latency", ack_cyc - t0, 17);

        // Abort: drop ws_cyc while beat 4 is on the bus
        start_txn(32'h0000_5000, 1'b0, '0, '0);
        for (int k = 0; k < 40 && n_acc < 5; k++) tick();
        ws_cyc = 1'b0; ws_stb = 1'b0;
        tick();
        chk("ab_stb_off", sram_stb, 0);
        chk("ab_dbg_idle", dbg_state, 2'b00);
        repeat (20) tick();
        chk("ab_no_ack", n_ack, 0);
        chk("ab_beats", n_acc, 5);
        chk("ab_dout_kept", ws_dout, prev_dout);

        // Read after abort completes normally
        for (int i = 0; i < 16; i++) exp_line[32*i +: 32] = mem[i];
        start_txn(32'h0000_1234, 1'b0, '0, '0);
        wait_ack();
        chk("rd3_latency", ack_cyc - t0, 17);
        chk("rd3_line", dout_cap, exp_line);

        // Asynchronous reset in the middle of a transfer
        start_txn(32'h0000_6000, 1'b0, '0, '0);
        repeat (6) tick();
        chk("mr_in_xfer", dbg_state, 2'b01);
        #2;
        rstn = 1'b0; ws_cyc = 1'b0; ws_stb = 1'b0;
        #1;
        chk("mr_stb", sram_stb, 0);
        chk("mr_addr", sram_addr, 0);
        chk("mr_dbg", dbg_state, 2'b00);
        chk("mr_dout", ws_dout, 0);
        tick();
        rstn = 1'b1;
        repeat (25) tick();
        chk("mr_no_ack", n_ack, 0);
        chk("mr_dbg_after", dbg_state, 2'b00);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
